fetch_stage: RTL and testbench

//  Instruction fetch stage. Sits directly upstream of decode: holds the PC, reads 16-bit

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control, instruction-memory and IF/ID signals.
// The stage itself connects through the master modport; its environment uses slave.
interface fetch_stage_if #(
  parameter int ADDR_W = 20
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_rdata;
  logic [6:0]        opcode;
  logic [2:0]        rsrc1;
  logic [2:0]        rsrc2;
  logic [2:0]        rdst;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] pc_next;
  logic              valid;

  modport master (
    input  stall, branch_taken, branch_target, imem_rdata,
    output imem_addr, opcode, rsrc1, rsrc2, rdst, imm, pc_next, valid
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_rdata,
    input  imem_addr, opcode, rsrc1, rsrc2, rdst, imm, pc_next, valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, assembles one- and two-word instructions
// from an asynchronous instruction ROM and presents registered IF/ID fields.
module fetch_stage #(
  parameter int                ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fif
);

  typedef enum logic [0:0] {
    S_WORD0 = 1'b0,
    S_IMM   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       stg_q, stg_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        rsrc1_q, rsrc1_d;
  logic [2:0]        rsrc2_q, rsrc2_d;
  logic [2:0]        rdst_q, rdst_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_inc;

  // Wraps modulo 2^ADDR_W, so a two-word instruction at the top address reads its immediate from 0.
  assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Next-state and IF/ID register computation; branch beats stall beats normal fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    stg_d     = stg_q;
    opcode_d  = opcode_q;
    rsrc1_d   = rsrc1_q;
    rsrc2_d   = rsrc2_q;
    rdst_d    = rdst_q;
    imm_d     = imm_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;

    if (fif.branch_taken) begin
      pc_d      = fif.branch_target;
      state_d   = S_WORD0;
      stg_d     = 16'h0000;
      opcode_d  = 7'd0;
      rsrc1_d   = 3'd0;
      rsrc2_d   = 3'd0;
      rdst_d    = 3'd0;
      imm_d     = 16'h0000;
      pc_next_d = {ADDR_W{1'b0}};
      valid_d   = 1'b0;
    end else if (fif.stall) begin
      state_d = state_q;
      pc_d    = pc_q;
    end else begin
      case (state_q)
        S_WORD0: begin
          pc_d = pc_inc;
          if (fif.imem_rdata[15]) begin
            // Word carries an immediate: park it and emit a bubble while the immediate is read.
            stg_d     = fif.imem_rdata;
            state_d   = S_IMM;
            opcode_d  = 7'd0;
            rsrc1_d   = 3'd0;
            rsrc2_d   = 3'd0;
            rdst_d    = 3'd0;
            imm_d     = 16'h0000;
            pc_next_d = {ADDR_W{1'b0}};
            valid_d   = 1'b0;
          end else begin
            state_d   = S_WORD0;
            opcode_d  = fif.imem_rdata[15:9];
            rsrc1_d   = fif.imem_rdata[8:6];
            rsrc2_d   = fif.imem_rdata[5:3];
            rdst_d    = fif.imem_rdata[2:0];
            imm_d     = 16'h0000;
            pc_next_d = pc_inc;
            valid_d   = 1'b1;
          end
        end
        S_IMM: begin
          pc_d      = pc_inc;
          state_d   = S_WORD0;
          opcode_d  = stg_q[15:9];
          rsrc1_d   = stg_q[8:6];
          rsrc2_d   = stg_q[5:3];
          rdst_d    = stg_q[2:0];
          imm_d     = fif.imem_rdata;
          pc_next_d = pc_inc;
          valid_d   = 1'b1;
        end
        default: begin
          state_d = S_WORD0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State, PC, staging and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_WORD0;
      pc_q      <= RESET_VEC;
      stg_q     <= 16'h0000;
      opcode_q  <= 7'd0;
      rsrc1_q   <= 3'd0;
      rsrc2_q   <= 3'd0;
      rdst_q    <= 3'd0;
      imm_q     <= 16'h0000;
      pc_next_q <= {ADDR_W{1'b0}};
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      stg_q     <= stg_d;
      opcode_q  <= opcode_d;
      rsrc1_q   <= rsrc1_d;
      rsrc2_q   <= rsrc2_d;
      rdst_q    <= rdst_d;
      imm_q     <= imm_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign fif.imem_addr = pc_q;
  assign fif.opcode    = opcode_q;
  assign fif.rsrc1     = rsrc1_q;
  assign fif.rsrc2     = rsrc2_q;
  assign fif.rdst      = rdst_q;
  assign fif.imm       = imm_q;
  assign fif.pc_next   = pc_next_q;
  assign fif.valid     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// checked against an instruction-level scoreboard built by walking program memory.
module tb_fetch_stage;

  typedef struct packed {
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic [15:0] imm;
    logic [19:0] pc_next;
    logic [19:0] pc;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem  [0:1023];
  logic [15:0] mem4 [0:15];
  rec_t        exp_q[$];

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(20)) fif ();
  fetch_stage_if #(.ADDR_W(4))  wif ();

  fetch_stage #(.ADDR_W(20), .RESET_VEC(20'h00020)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  fetch_stage #(.ADDR_W(4), .RESET_VEC(4'hF)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .fif (wif)
  );

  assign fif.imem_rdata = mem[fif.imem_addr[9:0]];
  assign wif.imem_rdata = mem4[wif.imem_addr];

  function automatic rec_t mk(input logic v, input logic [15:0] w, input logic [15:0] im,
                              input logic [19:0] pn, input logic [19:0] pc);
    return {v, w[15:9], w[8:6], w[5:3], w[2:0], im, pn, pc};
  endfunction

  function automatic rec_t observe();
    return {fif.valid, fif.opcode, fif.rsrc1, fif.rsrc2, fif.rdst, fif.imm, fif.pc_next, fif.imem_addr};
  endfunction

  // Expected IF/ID contents after each advancing edge, derived by walking the program.
  task automatic gen(input logic [19:0] start, input int n);
    logic [19:0] a;
    logic [15:0] w;
    exp_q.delete();
    a = start;
    while (exp_q.size() < n) begin
      w = mem[a[9:0]];
      if (!w[15]) begin
        exp_q.push_back(mk(1'b1, w, 16'h0000, a + 20'd1, a + 20'd1));
        a = a + 20'd1;
      end else begin
        exp_q.push_back(mk(1'b0, 16'h0000, 16'h0000, 20'd0, a + 20'd1));
        exp_q.push_back(mk(1'b1, w, mem[(a + 20'd1) & 20'h003FF], a + 20'd2, a + 20'd2));
        a = a + 20'd2;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic reset_w();
    @(negedge clk);
    rst_w = 1'b0;
    #2;
    @(negedge clk);
    rst_w = 1'b1;
  endtask

  task automatic test_reset();
    rec_t e;
    mem[32'h20] = 16'h1A53;
    rst = 1'b0;
    #2;
    e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00020);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", observe(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    e = mk(1'b1, 16'h1A53, 16'h0000, 20'h00021, 20'h00021);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL reset_first_insn: got %h expected %h", observe(), e);
    end
    checks++;
    if ({fif.opcode, fif.rsrc1, fif.rsrc2, fif.rdst} !== {7'h0D, 3'd1, 3'd2, 3'd3}) begin
      errors++;
      $display("FAIL reset_fields: got %h/%0d/%0d/%0d expected 0d/1/2/3",
               fif.opcode, fif.rsrc1, fif.rsrc2, fif.rdst);
    end
  endtask

  task automatic test_immediate();
    rec_t e;
    mem[32'h20] = 16'h8A53;
    mem[32'h21] = 16'hBEEF;
    do_reset();
    step();
    e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00021);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL imm_bubble: got %h expected %h", observe(), e);
    end
    step();
    e = mk(1'b1, 16'h8A53, 16'hBEEF, 20'h00022, 20'h00022);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL imm_deliver: got %h expected %h", observe(), e);
    end
    checks++;
    if (fif.opcode !== 7'h45) begin
      errors++;
      $display("FAIL imm_opcode: got %h expected 45", fif.opcode);
    end
  endtask

  task automatic test_stall();
    rec_t e;
    mem[32'h20] = 16'h8A53;
    mem[32'h21] = 16'hBEEF;
    mem[32'h22] = 16'h1234;
    do_reset();
    step();
    fif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00021);
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, observe(), e);
      end
    end
    fif.stall = 1'b0;
    step();
    e = mk(1'b1, 16'h8A53, 16'hBEEF, 20'h00022, 20'h00022);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL stall_release: got %h expected %h", observe(), e);
    end
    step();
    e = mk(1'b1, 16'h1234, 16'h0000, 20'h00023, 20'h00023);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL stall_next_insn: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_branch();
    rec_t e;
    mem[32'h20]  = 16'h8A53;
    mem[32'h21]  = 16'hBEEF;
    mem[32'h100] = 16'h2C41;
    do_reset();
    step();
    fif.stall         = 1'b1;
    fif.branch_taken  = 1'b1;
    fif.branch_target = 20'h00100;
    step();
    e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00100);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL branch_redirect: got %h expected %h", observe(), e);
    end
    fif.stall        = 1'b0;
    fif.branch_taken = 1'b0;
    step();
    e = mk(1'b1, 16'h2C41, 16'h0000, 20'h00101, 20'h00101);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL branch_target_insn: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_wrap();
    mem4[15] = 16'h1A53;
    mem4[0]  = 16'h0000;
    reset_w();
    step();
    checks++;
    if ({wif.valid, wif.opcode, wif.pc_next, wif.imem_addr} !== {1'b1, 7'h0D, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL wrap_one_word: got v=%b op=%h pn=%h addr=%h expected v=1 op=0d pn=0 addr=0",
               wif.valid, wif.opcode, wif.pc_next, wif.imem_addr);
    end
    mem4[15] = 16'h8A53;
    mem4[0]  = 16'hCAFE;
    reset_w();
    step();
    checks++;
    if ({wif.valid, wif.imem_addr} !== {1'b0, 4'h0}) begin
      errors++;
      $display("FAIL wrap_bubble: got v=%b addr=%h expected v=0 addr=0", wif.valid, wif.imem_addr);
    end
    step();
    checks++;
    if ({wif.valid, wif.opcode, wif.imm, wif.pc_next, wif.imem_addr} !==
        {1'b1, 7'h45, 16'hCAFE, 4'h1, 4'h1}) begin
      errors++;
      $display("FAIL wrap_two_word: got v=%b op=%h imm=%h pn=%h addr=%h expected v=1 op=45 imm=cafe pn=1 addr=1",
               wif.valid, wif.opcode, wif.imm, wif.pc_next, wif.imem_addr);
    end
  endtask

  task automatic test_async_reset();
    rec_t e;
    mem[32'h20] = 16'h1A53;
    mem[32'h21] = 16'h8A53;
    mem[32'h22] = 16'h7777;
    do_reset();
    step();
    #2;
    rst = 1'b0;
    #1;
    e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00020);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL async_rst_valid: got %h expected %h", observe(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL async_rst_imm: got %h expected %h", observe(), e);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    e = mk(1'b1, 16'h1A53, 16'h0000, 20'h00021, 20'h00021);
    checks++;
    if (observe() !== e) begin
      errors++;
      $display("FAIL async_rst_restart: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_random();
    rec_t cur;
    rec_t e;
    logic br;
    logic st;
    logic [19:0] tgt;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 16'($urandom);
    end
    do_reset();
    gen(20'h00020, 500);
    cur = mk(1'b0, 16'h0000, 16'h0000, 20'd0, 20'h00020);
    for (int c = 0; c < 400; c++) begin
      br  = ($urandom_range(0, 11) == 0);
      st  = ($urandom_range(0, 3) == 0);
      tgt = 20'($urandom_range(0, 1023));
      fif.branch_taken  = br;
      fif.stall         = st;
      fif.branch_target = tgt;
      step();
      if (br) begin
        e = mk(1'b0, 16'h0000, 16'h0000, 20'd0, tgt);
        gen(tgt, 500);
      end else if (st) begin
        e = cur;
      end else begin
        e = exp_q.pop_front();
      end
      cur = e;
      checks++;
      if (observe() !== e) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h expected %h (br=%b st=%b)", c, observe(), e, br, st);
      end
    end
    fif.branch_taken = 1'b0;
    fif.stall        = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    rst_w = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    fif.stall         = 1'b0;
    fif.branch_taken  = 1'b0;
    fif.branch_target = 20'd0;
    wif.stall         = 1'b0;
    wif.branch_taken  = 1'b0;
    wif.branch_target = 4'd0;
    #1;
    test_reset();
    test_immediate();
    test_stall();
    test_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
